// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int         NREQ     = 3;
  localparam logic [3:0] BE_FULL  = 4'b1111;
  localparam int         REG_ZERO = 0;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LD  = 2'd1,
    REQ_PC  = 2'd2
  } req_id_e;

  // Successor of a requester id in round-robin order.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == 2'(NREQ - 1)) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry write-request buffer for a single requester. Requests to the zero
// register or with no byte enabled are accepted but never occupy the slot.
module wb_slot
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [3:0]        in_be_i,
  input  logic              grant_i,
  output logic              in_ready_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [3:0]        be_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        be_q;
  logic              accept, keep;

  // A granted slot drains at the same edge, so it may be refilled then.
  assign in_ready_o = !rst && (!valid_q || grant_i);
  assign accept     = in_valid_i && in_ready_o;
  assign keep       = accept && (in_addr_i != ADDR_W'(REG_ZERO)) && (in_be_i != 4'b0000);

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    valid_d = valid_q;
    if (grant_i) valid_d = 1'b0;
    if (keep)    valid_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // NOTE: the payload is deliberately not reset; it is only observed while
  // valid_q is set, and leaving it out of reset keeps it a plain enable flop.
  always_ff @(posedge clk) begin
    if (keep) begin
      addr_q <= in_addr_i;
      data_q <= in_data_i;
      be_q   <= in_be_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign be_o    = be_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port, with
// RAW hazard reporting. Define REGFILE_WB_FORWARD_EN to add full-word forwarding.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*4-1:0]      req_be,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [3:0]             wr_be,
  output logic [1:0]             wr_src,
  input  logic [ADDR_W-1:0]      chk_rs,
  input  logic [ADDR_W-1:0]      chk_rt,
  output logic                   hazard_rs,
  output logic                   hazard_rt
`ifdef REGFILE_WB_FORWARD_EN
  ,
  output logic                   fwd_rs_valid,
  output logic [DATA_W-1:0]      fwd_rs_data,
  output logic                   fwd_rt_valid,
  output logic [DATA_W-1:0]      fwd_rt_data
`endif
);

  logic [NREQ-1:0]   slot_valid;
  logic [ADDR_W-1:0] slot_addr [NREQ];
  logic [DATA_W-1:0] slot_data [NREQ];
  logic [3:0]        slot_be   [NREQ];
  logic [NREQ-1:0]   grant;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (req_valid[i]),
      .in_addr_i  (req_addr[i*ADDR_W +: ADDR_W]),
      .in_data_i  (req_data[i*DATA_W +: DATA_W]),
      .in_be_i    (req_be[i*4 +: 4]),
      .grant_i    (grant[i]),
      .in_ready_o (req_ready[i]),
      .valid_o    (slot_valid[i]),
      .addr_o     (slot_addr[i]),
      .data_o     (slot_data[i]),
      .be_o       (slot_be[i])
    );
  end

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [3:0]        wr_be_q, wr_be_d;
  logic [1:0]        wr_src_q, wr_src_d;
  logic [1:0]        arb_scan, grant_id;
  logic              grant_any;

  // First valid slot at or after the pointer wins.
  always_comb begin
    arb_scan  = rr_ptr_q;
    grant_id  = rr_ptr_q;
    grant_any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!grant_any && slot_valid[arb_scan]) begin
        grant_any = 1'b1;
        grant_id  = arb_scan;
      end
      arb_scan = next_id(arb_scan);
    end
    grant = '0;
    if (grant_any) grant[grant_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = grant_any;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    wr_src_d  = wr_src_q;
    if (grant_any) begin
      rr_ptr_d  = next_id(grant_id);
      wr_addr_d = slot_addr[grant_id];
      wr_data_d = slot_data[grant_id];
      wr_be_d   = slot_be[grant_id];
      wr_src_d  = grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= 4'b0000;
      wr_src_q  <= 2'(REQ_ALU);
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_be   = wr_be_q;
  assign wr_src  = wr_src_q;

  // Index 0 checks rs, index 1 checks rt. The first match in priority order
  // (output stage, then slots from the pointer) decides whether it forwards.
  logic [ADDR_W-1:0] chk_addr [2];
  logic [1:0]        haz_hit;
  logic [1:0]        haz_scan;
  logic              haz_done;
`ifdef REGFILE_WB_FORWARD_EN
  logic [1:0]        haz_full;
  logic [DATA_W-1:0] haz_data [2];
`endif

  assign chk_addr[0] = chk_rs;
  assign chk_addr[1] = chk_rt;

  always_comb begin
    haz_hit  = '0;
    haz_scan = rr_ptr_q;
    haz_done = 1'b0;
`ifdef REGFILE_WB_FORWARD_EN
    haz_full    = '0;
    haz_data[0] = '0;
    haz_data[1] = '0;
`endif
    for (int p = 0; p < 2; p++) begin
      haz_scan = rr_ptr_q;
      haz_done = 1'b0;
      if (chk_addr[p] != ADDR_W'(REG_ZERO)) begin
        if (wr_en_q && (wr_addr_q == chk_addr[p])) begin
          haz_done   = 1'b1;
          haz_hit[p] = 1'b1;
`ifdef REGFILE_WB_FORWARD_EN
          haz_full[p] = (wr_be_q == BE_FULL);
          haz_data[p] = wr_data_q;
`endif
        end
        for (int off = 0; off < NREQ; off++) begin
          if (!haz_done && slot_valid[haz_scan] && (slot_addr[haz_scan] == chk_addr[p])) begin
            haz_done   = 1'b1;
            haz_hit[p] = 1'b1;
`ifdef REGFILE_WB_FORWARD_EN
            haz_full[p] = (slot_be[haz_scan] == BE_FULL);
            haz_data[p] = slot_data[haz_scan];
`endif
          end
          haz_scan = next_id(haz_scan);
        end
      end
    end
  end

`ifdef REGFILE_WB_FORWARD_EN
  assign hazard_rs    = haz_hit[0] && !haz_full[0];
  assign hazard_rt    = haz_hit[1] && !haz_full[1];
  assign fwd_rs_valid = haz_full[0];
  assign fwd_rt_valid = haz_full[1];
  assign fwd_rs_data  = haz_data[0];
  assign fwd_rt_data  = haz_data[1];
`else
  assign hazard_rs = haz_hit[0];
  assign hazard_rt = haz_hit[1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter plus hand-written reset
// and forwarding sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [11:0] req_be = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [1:0]  wr_src;
  logic [4:0]  chk_rs = '0;
  logic [4:0]  chk_rt = '0;
  logic        hazard_rs, hazard_rt;
`ifdef REGFILE_WB_FORWARD_EN
  logic        fwd_rs_valid, fwd_rt_valid;
  logic [31:0] fwd_rs_data, fwd_rt_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_be    (req_be),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .wr_src    (wr_src),
    .chk_rs    (chk_rs),
    .chk_rt    (chk_rt),
    .hazard_rs (hazard_rs),
    .hazard_rt (hazard_rt)
`ifdef REGFILE_WB_FORWARD_EN
    ,
    .fwd_rs_valid (fwd_rs_valid),
    .fwd_rs_data  (fwd_rs_data),
    .fwd_rt_valid (fwd_rt_valid),
    .fwd_rt_data  (fwd_rt_data)
`endif
  );

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [3:0]  b0, b1, b2;
    logic [4:0]  rs, rt;
    logic [2:0]  e_ready;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic [1:0]  e_src;
    logic        e_hrs, e_hrt;
    logic        e_frs, e_frt;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                       input logic [31:0] d0, d1, d2, input logic [3:0] b0, b1, b2,
                       input logic [4:0] rs, rt);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    req_be    = {b2, b1, b0};
    chk_rs    = rs;
    chk_rt    = rt;
  endtask

  vec_t vt [21];

  initial begin
    // Fields: valid, addr0..2, data0..2, be0..2, chk_rs, chk_rt |
    //         ready, wr_en, wr_addr, wr_data, wr_be, wr_src, hz_rs, hz_rt, fwd_rs, fwd_rt
    vt[0]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd0, 5'd0,
               3'b111, 1'b0, 5'd0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 5'd0, 5'd0,
               3'b111, 1'b0, 5'd0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd5, 5'd0,
               3'b111, 1'b0, 5'd0, 32'h0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd5, 5'd0,
               3'b111, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd5, 5'd0,
               3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77, 4'h0, 4'h0, 4'h3, 5'd0, 5'd0,
               3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd0, 5'd7,
               3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 4'hF, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{3'b111, 5'd3, 5'd4, 5'd31, 32'h33, 32'h44, 32'h31F, 4'hF, 4'hC, 4'h1, 5'd31, 5'd7,
               3'b111, 1'b1, 5'd7, 32'h77, 4'h3, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{3'b001, 5'd6, 5'd0, 5'd0, 32'h66, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 5'd31, 5'd7,
               3'b001, 1'b0, 5'd7, 32'h77, 4'h3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd3, 5'd4,
               3'b010, 1'b1, 5'd3, 32'h33, 4'hF, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[10] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd31, 5'd6,
               3'b110, 1'b1, 5'd4, 32'h44, 4'hC, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[11] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd31, 5'd6,
               3'b111, 1'b1, 5'd31, 32'h31F, 4'h1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[12] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd31, 5'd6,
               3'b111, 1'b1, 5'd6, 32'h66, 4'hF, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[13] = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hBAD, 32'h0, 4'h0, 4'hF, 4'h0, 5'd0, 5'd0,
               3'b111, 1'b0, 5'd6, 32'h66, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'hBAD, 4'h0, 4'h0, 4'h0, 5'd0, 5'd0,
               3'b111, 1'b0, 5'd6, 32'h66, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd9, 5'd0,
               3'b111, 1'b0, 5'd6, 32'h66, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd9, 5'd0,
               3'b111, 1'b0, 5'd6, 32'h66, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[17] = '{3'b010, 5'd0, 5'd8, 5'd0, 32'h0, 32'h88, 32'h0, 4'h0, 4'hF, 4'h0, 5'd8, 5'd0,
               3'b111, 1'b0, 5'd6, 32'h66, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[18] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd8, 5'd0,
               3'b111, 1'b0, 5'd6, 32'h66, 4'hF, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[19] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd8, 5'd0,
               3'b111, 1'b1, 5'd8, 32'h88, 4'hF, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[20] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd8, 5'd0,
               3'b111, 1'b0, 5'd8, 32'h88, 4'hF, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Power-on reset.
    #2 rst = 1'b1;
    #1;
    check("por wr_en",     64'(wr_en),     64'(1'b0));
    check("por req_ready", 64'(req_ready), 64'(3'b000));
    check("por wr_addr",   64'(wr_addr),   64'(5'd0));
    check("por wr_data",   64'(wr_data),   64'(32'h0));
    check("por wr_be",     64'(wr_be),     64'(4'h0));
    check("por wr_src",    64'(wr_src),    64'(2'd0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vt[i].valid, vt[i].a0, vt[i].a1, vt[i].a2, vt[i].d0, vt[i].d1, vt[i].d2,
            vt[i].b0, vt[i].b1, vt[i].b2, vt[i].rs, vt[i].rt);
      #1;
      check($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vt[i].e_ready));
      check($sformatf("v%0d wr_en", i),     64'(wr_en),     64'(vt[i].e_en));
      check($sformatf("v%0d wr_addr", i),   64'(wr_addr),   64'(vt[i].e_addr));
      check($sformatf("v%0d wr_data", i),   64'(wr_data),   64'(vt[i].e_data));
      check($sformatf("v%0d wr_be", i),     64'(wr_be),     64'(vt[i].e_be));
      check($sformatf("v%0d wr_src", i),    64'(wr_src),    64'(vt[i].e_src));
`ifdef REGFILE_WB_FORWARD_EN
      check($sformatf("v%0d hazard_rs", i), 64'(hazard_rs), 64'(vt[i].e_hrs & ~vt[i].e_frs));
      check($sformatf("v%0d hazard_rt", i), 64'(hazard_rt), 64'(vt[i].e_hrt & ~vt[i].e_frt));
      check($sformatf("v%0d fwd_rs_valid", i), 64'(fwd_rs_valid), 64'(vt[i].e_frs));
      check($sformatf("v%0d fwd_rt_valid", i), 64'(fwd_rt_valid), 64'(vt[i].e_frt));
`else
      check($sformatf("v%0d hazard_rs", i), 64'(hazard_rs), 64'(vt[i].e_hrs));
      check($sformatf("v%0d hazard_rt", i), 64'(hazard_rt), 64'(vt[i].e_hrt));
`endif
    end

    // Reset mid-cycle while a write is on the port and the LD slot holds another.
    @(negedge clk);
    drive(3'b010, 5'd0, 5'd12, 5'd0, 32'h0, 32'hC0, 32'h0, 4'h0, 4'hF, 4'h0, 5'd13, 5'd0);
    @(negedge clk);
    drive(3'b010, 5'd0, 5'd13, 5'd0, 32'h0, 32'hD0, 32'h0, 4'h0, 4'hF, 4'h0, 5'd13, 5'd0);
    @(negedge clk);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd13, 5'd0);
    #1;
    check("pre-rst wr_en",   64'(wr_en),   64'(1'b1));
    check("pre-rst wr_addr", 64'(wr_addr), 64'(5'd12));
    check("pre-rst wr_src",  64'(wr_src),  64'(2'd1));
`ifdef REGFILE_WB_FORWARD_EN
    check("pre-rst fwd_rs_valid", 64'(fwd_rs_valid), 64'(1'b1));
    check("pre-rst fwd_rs_data",  64'(fwd_rs_data),  64'(32'hD0));
`else
    check("pre-rst hazard_rs", 64'(hazard_rs), 64'(1'b1));
`endif
    #1 rst = 1'b1;
    #1;
    check("rst wr_en",     64'(wr_en),     64'(1'b0));
    check("rst req_ready", 64'(req_ready), 64'(3'b000));
    check("rst wr_addr",   64'(wr_addr),   64'(5'd0));
    check("rst hazard_rs", 64'(hazard_rs), 64'(1'b0));
    @(posedge clk);
    #1;
    check("rst held req_ready", 64'(req_ready), 64'(3'b000));
    check("rst held wr_en",     64'(wr_en),     64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rst c%0d wr_en", c),     64'(wr_en),     64'(1'b0));
      check($sformatf("post-rst c%0d hazard_rs", c), 64'(hazard_rs), 64'(1'b0));
    end
    check("post-rst req_ready", 64'(req_ready), 64'(3'b111));

`ifdef REGFILE_WB_FORWARD_EN
    // Full-word pending write forwards; a partial write to the same register stalls.
    @(negedge clk);
    drive(3'b001, 5'd9, 5'd0, 5'd0, 32'h12345678, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 5'd0, 5'd9);
    @(negedge clk);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd0, 5'd9);
    #1;
    check("fwd full fwd_rt_valid", 64'(fwd_rt_valid), 64'(1'b1));
    check("fwd full fwd_rt_data",  64'(fwd_rt_data),  64'(32'h12345678));
    check("fwd full hazard_rt",    64'(hazard_rt),    64'(1'b0));
    repeat (3) @(negedge clk);
    drive(3'b001, 5'd9, 5'd0, 5'd0, 32'hAAAA, 32'h0, 32'h0, 4'h3, 4'h0, 4'h0, 5'd0, 5'd9);
    @(negedge clk);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd0, 5'd9);
    #1;
    check("fwd part hazard_rt",    64'(hazard_rt),    64'(1'b1));
    check("fwd part fwd_rt_valid", 64'(fwd_rt_valid), 64'(1'b0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
